neighbour_fetch: RTL and testbench
==================================

NEIGHBOUR_FETCH -- requirements
Module: neighbour_fetch

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 16, pixel width; ADDR_W, 16, image-RAM word-address width; DIM_W, 16, coordinate/dimension width.
REQ-002 clk  in  1  single clock; all state on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 sw_val, sh_val  in  DIM_W  source image width and height in pixels (1..2^DIM_W-1); sampled at request accept.
REQ-005 req_valid  in  1  coordinate request from top_processor (driven by its pixel_rdy).
REQ-006 src_x, src_y  in  DIM_W  1-based source column and row (pixel_val, pixel_val11).
REQ-007 req_ready  out  1  high only in IDLE.
REQ-008 mem_addr  out  ADDR_W  synchronous image-RAM read address, row-major, 0-based.
REQ-009 mem_rd  out  1  read strobe.
REQ-010 mem_rdata  in  DATA_W  RAM data, valid exactly one cycle after mem_rd.
REQ-011 imgmn, imgm1n, imgmn1, imgm1n1  out  DATA_W each  pixels at (x,y), (x+1,y), (x,y+1), (x+1,y+1).
REQ-012 out_valid  out  1  neighbourhood valid; out_ready  in  1  consumer accept; coord_err  out  1  request was out of range.

Function
REQ-013 The request SHALL be accepted on a clk edge where req_valid and req_ready are both high; src_x, src_y, sw_val and sh_val SHALL be registered then.
REQ-014 Address SHALL be (row-1)*sw_val + (col-1), truncated to ADDR_W bits; the row base SHALL be computed once per request.
REQ-015 Edge clamp: x1 = src_x+1 if src_x < sw_val, else src_x; y1 = src_y+1 if src_y < sh_val, else src_y.
REQ-016 FSM states SHALL be IDLE, A0, A1, A2, A3, CAP, OUT.
REQ-017 IDLE -> A0 on accept; A0..A3 SHALL issue reads of (x,y), (x1,y), (x,y1), (x1,y1) in that order, mem_rd high exactly in A0..A3.
REQ-018 mem_rdata SHALL be captured into imgmn in A1, imgm1n in A2, imgmn1 in A3, and imgm1n1 in CAP; CAP -> OUT unconditionally.
REQ-019 out_valid SHALL be high only in OUT, first asserted 5 cycles after the accept edge; OUT -> IDLE on the edge where out_ready is high.
REQ-020 Outputs SHALL hold stable while out_valid is high and out_ready is low, for any number of cycles.
REQ-021 Out of range (src_x = 0, src_y = 0, src_x > sw_val, or src_y > sh_val) SHALL cause IDLE -> OUT directly, with no mem_rd, all four pixels = 0, and coord_err = 1 for that OUT; coord_err SHALL be 0 otherwise.
REQ-022 req_valid outside IDLE SHALL be ignored; a request is never lost, because req_ready is low.
REQ-023 In OUT with out_ready high, the FSM SHALL go to IDLE first; a new request can be accepted no earlier than the next edge.
REQ-024 mem_addr SHALL hold its last value when mem_rd is low.

Reset
REQ-025 Reset SHALL force the FSM to IDLE asynchronously.
REQ-026 During reset, the following SHALL be 0: mem_rd, mem_addr, out_valid, coord_err, all pixel outputs, and the registered coordinates.
REQ-027 During reset, req_ready SHALL be 0.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch with no output; after release, req_ready SHALL be 1 on the first cycle.

Structure
REQ-029 State encoding and the DATA_W/ADDR_W/DIM_W defaults SHALL live in the shared configure.h alongside INPUT_IMAGE_SIZE and OUTPUT_IMAGE_SIZE.
REQ-030 A single sub-module, nf_addr_gen, SHALL hold the range check, the clamp and the row-major address arithmetic; the FSM and capture registers SHALL stay in neighbour_fetch.

Verification
REQ-031 Set sw=sh=4 and RAM[i]=i+0x100; request (2,3) -> addresses 9,10,13,14; outputs 0x109, 0x10A, 0x10D, 0x10E; out_valid 5 cycles after the accept edge.
REQ-032 Set sw=sh=4; request (4,4) -> addresses 15,15,15,15; all outputs 0x10F.
REQ-033 Request (0,2), then (5,1) -> no mem_rd; out_valid with zeros and coord_err=1 each time.
REQ-034 Hold out_ready low for 7 cycles in OUT -> outputs and out_valid stable; req_valid pulses ignored; accept on the 8th cycle, then IDLE.
REQ-035 Assert reset in A2 -> out_valid stays 0, and the next request (1,1) returns 0x100, 0x101, 0x104, 0x105.
REQ-036 Drive 16 back-to-back requests scanning a 4x4 image with out_ready held high -> one output every 7 cycles, matching a reference model bit-exactly.

Source files
------------

// File: rtl/neighbour_fetch_pkg.sv
// Shared configuration for the neighbour fetch block: default widths,
// image sizes, FSM state encoding and a small state-decode helper.
package neighbour_fetch_pkg;

  localparam int NF_DATA_W = 16;
  localparam int NF_ADDR_W = 16;
  localparam int NF_DIM_W  = 16;

  // Image RAM depth (input) and scaled image size (output), in pixels.
  localparam int INPUT_IMAGE_SIZE  = 32'd4096;
  localparam int OUTPUT_IMAGE_SIZE = 32'd16384;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A0   = 3'd1,
    ST_A1   = 3'd2,
    ST_A2   = 3'd3,
    ST_A3   = 3'd4,
    ST_CAP  = 3'd5,
    ST_OUT  = 3'd6
  } nf_state_e;

  // True for the four states that issue an image-RAM read.
  function automatic logic is_read_state(input nf_state_e s);
    case (s)
      ST_A0, ST_A1, ST_A2, ST_A3: is_read_state = 1'b1;
      default:                    is_read_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nf_addr_gen.sv
// Address generator for neighbour_fetch (purely combinational).
// Inputs : x, y, sw, sh      request coordinates (1-based) and image size
//          base_sel, col_sel row base and 1-based column of the read to address
// Outputs: range_err         coordinate outside 1..sw / 1..sh
//          x1                right-neighbour column, clamped at the right edge
//          row_base0/1       word address of row y and of row y1 (clamped)
//          addr_sel          base_sel + col_sel - 1
module nf_addr_gen
  import neighbour_fetch_pkg::*;
#(
  parameter int ADDR_W = NF_ADDR_W,
  parameter int DIM_W  = NF_DIM_W
) (
  input  logic [DIM_W-1:0]  x,
  input  logic [DIM_W-1:0]  y,
  input  logic [DIM_W-1:0]  sw,
  input  logic [DIM_W-1:0]  sh,
  input  logic [ADDR_W-1:0] base_sel,
  input  logic [DIM_W-1:0]  col_sel,
  output logic              range_err,
  output logic [DIM_W-1:0]  x1,
  output logic [ADDR_W-1:0] row_base0,
  output logic [ADDR_W-1:0] row_base1,
  output logic [ADDR_W-1:0] addr_sel
);

  localparam int PROD_W = 2 * DIM_W;

  logic [PROD_W-1:0] row_prod_s;

  // Range check, edge clamp and row-major address arithmetic.
  always_comb begin
    // Full-width product, then truncated to the RAM address width.
    row_prod_s = PROD_W'(y - DIM_W'(1'b1)) * PROD_W'(sw);
    row_base0  = ADDR_W'(row_prod_s);
    // The lower row is one stride further down unless y is already the bottom row.
    if (y < sh) begin
      row_base1 = row_base0 + ADDR_W'(sw);
    end else begin
      row_base1 = row_base0;
    end
    if (x < sw) begin
      x1 = x + DIM_W'(1'b1);
    end else begin
      x1 = x;
    end
    range_err = (x == {DIM_W{1'b0}}) || (y == {DIM_W{1'b0}}) || (x > sw) || (y > sh);
    addr_sel  = base_sel + ADDR_W'(col_sel - DIM_W'(1'b1));
  end

endmodule

// File: rtl/neighbour_fetch.sv
// Fetches the 2x2 neighbourhood (x,y),(x+1,y),(x,y+1),(x+1,y+1) of a source
// pixel from a synchronous image RAM, clamping at the right/bottom edges.
// Ports: clk/reset (async active-low); sw_val/sh_val image size; req_valid,
// src_x, src_y, req_ready request handshake; mem_addr, mem_rd, mem_rdata RAM
// read port (data one cycle after mem_rd); imgmn, imgm1n, imgmn1, imgm1n1
// neighbourhood pixels; out_valid/out_ready output handshake; coord_err flags
// an out-of-range request (pixels forced to zero, no RAM reads).
module neighbour_fetch
  import neighbour_fetch_pkg::*;
#(
  parameter int DATA_W = NF_DATA_W,
  parameter int ADDR_W = NF_ADDR_W,
  parameter int DIM_W  = NF_DIM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIM_W-1:0]  sw_val,
  input  logic [DIM_W-1:0]  sh_val,
  input  logic              req_valid,
  input  logic [DIM_W-1:0]  src_x,
  input  logic [DIM_W-1:0]  src_y,
  output logic              req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] imgmn,
  output logic [DATA_W-1:0] imgm1n,
  output logic [DATA_W-1:0] imgmn1,
  output logic [DATA_W-1:0] imgm1n1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              coord_err
);

  nf_state_e         state_r, state_nx_s;
  logic [DIM_W-1:0]  x_r, y_r, sw_r, sh_r, x1_r;
  logic [ADDR_W-1:0] base0_r, base1_r, mem_addr_r;
  logic              mem_rd_r, out_valid_r, coord_err_r;
  logic [DATA_W-1:0] pix00_r, pix10_r, pix01_r, pix11_r;

  logic [DIM_W-1:0]  gx_s, gy_s, gsw_s, gsh_s, x1_s, col_sel_s;
  logic [ADDR_W-1:0] row_base0_s, row_base1_s, base_sel_s, addr_sel_s;
  logic              range_err_s, accept_s, addr_load_s;

  // Address generator sees the live request while idle, the held one otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      gx_s  = src_x;
      gy_s  = src_y;
      gsw_s = sw_val;
      gsh_s = sh_val;
    end else begin
      gx_s  = x_r;
      gy_s  = y_r;
      gsw_s = sw_r;
      gsh_s = sh_r;
    end
  end

  nf_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .x         (gx_s),
    .y         (gy_s),
    .sw        (gsw_s),
    .sh        (gsh_s),
    .base_sel  (base_sel_s),
    .col_sel   (col_sel_s),
    .range_err (range_err_s),
    .x1        (x1_s),
    .row_base0 (row_base0_s),
    .row_base1 (row_base1_s),
    .addr_sel  (addr_sel_s)
  );

  // Next state and the address of the read issued in the next state.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    addr_load_s = 1'b0;
    base_sel_s  = base0_r;
    col_sel_s   = x_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (range_err_s) begin
            state_nx_s = ST_OUT;
          end else begin
            // First read uses the freshly computed row base, not the registers.
            state_nx_s  = ST_A0;
            addr_load_s = 1'b1;
            base_sel_s  = row_base0_s;
            col_sel_s   = src_x;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_A0: begin
        state_nx_s  = ST_A1;
        addr_load_s = 1'b1;
        base_sel_s  = base0_r;
        col_sel_s   = x1_r;
      end
      ST_A1: begin
        state_nx_s  = ST_A2;
        addr_load_s = 1'b1;
        base_sel_s  = base1_r;
        col_sel_s   = x_r;
      end
      ST_A2: begin
        state_nx_s  = ST_A3;
        addr_load_s = 1'b1;
        base_sel_s  = base1_r;
        col_sel_s   = x1_r;
      end
      ST_A3:  state_nx_s = ST_CAP;
      ST_CAP: state_nx_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request capture, RAM read port, pixel capture and output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r         <= {DIM_W{1'b0}};
      y_r         <= {DIM_W{1'b0}};
      sw_r        <= {DIM_W{1'b0}};
      sh_r        <= {DIM_W{1'b0}};
      x1_r        <= {DIM_W{1'b0}};
      base0_r     <= {ADDR_W{1'b0}};
      base1_r     <= {ADDR_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_rd_r    <= 1'b0;
      pix00_r     <= {DATA_W{1'b0}};
      pix10_r     <= {DATA_W{1'b0}};
      pix01_r     <= {DATA_W{1'b0}};
      pix11_r     <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      coord_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        x_r     <= src_x;
        y_r     <= src_y;
        sw_r    <= sw_val;
        sh_r    <= sh_val;
        x1_r    <= x1_s;
        base0_r <= row_base0_s;
        base1_r <= row_base1_s;
      end
      // Address only moves when a read is issued; otherwise it holds.
      if (addr_load_s) begin
        mem_addr_r <= addr_sel_s;
      end
      mem_rd_r <= is_read_state(state_nx_s);
      // RAM data lags its read by one cycle, so each capture is one state late.
      case (state_r)
        ST_IDLE: begin
          if (accept_s && range_err_s) begin
            pix00_r <= {DATA_W{1'b0}};
            pix10_r <= {DATA_W{1'b0}};
            pix01_r <= {DATA_W{1'b0}};
            pix11_r <= {DATA_W{1'b0}};
          end
        end
        ST_A1:   pix00_r <= mem_rdata;
        ST_A2:   pix10_r <= mem_rdata;
        ST_A3:   pix01_r <= mem_rdata;
        ST_CAP:  pix11_r <= mem_rdata;
        default: begin
        end
      endcase
      out_valid_r <= (state_nx_s == ST_OUT);
      if (state_r == ST_OUT) begin
        coord_err_r <= coord_err_r & ~out_ready;
      end else begin
        coord_err_r <= accept_s & range_err_s;
      end
    end
  end

  // Ready is gated by reset so it reads low while reset is held.
  assign req_ready = reset & (state_r == ST_IDLE);
  assign mem_addr  = mem_addr_r;
  assign mem_rd    = mem_rd_r;
  assign imgmn     = pix00_r;
  assign imgm1n    = pix10_r;
  assign imgmn1    = pix01_r;
  assign imgm1n1   = pix11_r;
  assign out_valid = out_valid_r;
  assign coord_err = coord_err_r;

endmodule

// File: tb/tb_neighbour_fetch.sv
module tb_neighbour_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] sw_val, sh_val, src_x, src_y;
  logic        req_valid, req_ready, mem_rd, out_valid, out_ready, coord_err;
  logic [15:0] mem_addr, mem_rdata;
  logic [15:0] imgmn, imgm1n, imgmn1, imgm1n1;

  int n_checks = 0;
  int n_fail   = 0;

  neighbour_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .sw_val    (sw_val),
    .sh_val    (sh_val),
    .req_valid (req_valid),
    .src_x     (src_x),
    .src_y     (src_y),
    .req_ready (req_ready),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .imgmn     (imgmn),
    .imgm1n    (imgm1n),
    .imgmn1    (imgmn1),
    .imgm1n1   (imgm1n1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coord_err (coord_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Image RAM: word i holds i + 0x100, one-cycle read latency.
  initial mem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr + 16'h0100;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_addr(input int c, input int r, input int w);
    ref_addr = 16'((r - 1) * w + (c - 1));
  endfunction

  function automatic int clamp_next(input int v, input int lim);
    clamp_next = (v < lim) ? v + 1 : v;
  endfunction

  int          cyc = 0;
  logic        m_busy = 1'b0;
  logic        m_err = 1'b0;
  int          m_acc = 0;
  int          m_lat = 0;
  logic [15:0] m_adr [4];
  logic [15:0] m_pix [4];
  int          d;
  logic        exp_valid, exp_ready, exp_rd, req_bad;

  assign d         = cyc - m_acc;
  assign exp_valid = reset && m_busy && (d >= m_lat);
  assign exp_ready = reset && !m_busy;
  assign exp_rd    = reset && m_busy && !m_err && (d >= 0) && (d <= 3);
  assign req_bad   = (src_x == 16'd0) || (src_y == 16'd0) || (src_x > sw_val) || (src_y > sh_val);

  // Model: one outstanding request; reads at edges 0..3 after accept, output
  // from edge 5 (edge 0 when the request is out of range) until accepted.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (exp_valid && out_ready) m_busy <= 1'b0;
    end else if (req_valid) begin
      m_busy   <= 1'b1;
      m_acc    <= cyc + 1;
      m_err    <= req_bad;
      m_lat    <= req_bad ? 0 : 5;
      m_adr[0] <= ref_addr(src_x, src_y, sw_val);
      m_adr[1] <= ref_addr(clamp_next(src_x, sw_val), src_y, sw_val);
      m_adr[2] <= ref_addr(src_x, clamp_next(src_y, sh_val), sw_val);
      m_adr[3] <= ref_addr(clamp_next(src_x, sw_val), clamp_next(src_y, sh_val), sw_val);
      m_pix[0] <= req_bad ? 16'h0 : ref_addr(src_x, src_y, sw_val) + 16'h0100;
      m_pix[1] <= req_bad ? 16'h0 : ref_addr(clamp_next(src_x, sw_val), src_y, sw_val) + 16'h0100;
      m_pix[2] <= req_bad ? 16'h0 : ref_addr(src_x, clamp_next(src_y, sh_val), sw_val) + 16'h0100;
      m_pix[3] <= req_bad ? 16'h0 : ref_addr(clamp_next(src_x, sw_val), clamp_next(src_y, sh_val), sw_val) + 16'h0100;
    end
  end

  // Compare process: every cycle, on the falling edge.
  logic [15:0] addr_q [$];
  always @(negedge clk) begin
    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    check("mem_rd", mem_rd, exp_rd);
    check("coord_err", coord_err, exp_valid && m_err);
    if (exp_rd) check("mem_addr", mem_addr, m_adr[d]);
    if (exp_valid) begin
      check("imgmn", imgmn, m_pix[0]);
      check("imgm1n", imgm1n, m_pix[1]);
      check("imgmn1", imgmn1, m_pix[2]);
      check("imgm1n1", imgm1n1, m_pix[3]);
    end
    if (mem_rd) addr_q.push_back(mem_addr);
  end

  // ---------------- directed stimulus ----------------
  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic req(input logic [15:0] x, input logic [15:0] y, output int acc_cyc);
    int n;
    src_x = x;
    src_y = y;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", req_ready, 1'b1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("valid_wait", out_valid, 1'b1);
  endtask

  task automatic pix4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] e);
    check({tag, "_mn"}, imgmn, a);
    check({tag, "_m1n"}, imgm1n, b);
    check({tag, "_mn1"}, imgmn1, c);
    check({tag, "_m1n1"}, imgm1n1, e);
  endtask

  initial begin
    int lat, acc, base, prev_acc;
    logic [15:0] s0, s1, s2, s3;
    reset = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b1;
    src_x = 16'd0;
    src_y = 16'd0;
    sw_val = 16'd4;
    sh_val = 16'd4;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_pix", imgmn | imgm1n | imgmn1 | imgm1n1, 16'h0);
    check("rst_valid_err", {out_valid, coord_err}, 2'b00);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("rel_ready", req_ready, 1'b1);
    @(negedge clk);

    // (2,3) on a 4x4 image
    base = addr_q.size();
    req(16'd2, 16'd3, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    check("t1_latency", lat, 5);
    pix4("t1", 16'h0109, 16'h010A, 16'h010D, 16'h010E);
    check("t1_nreads", addr_q.size() - base, 4);
    check("t1_a0", addr_q[base], 16'd9);
    check("t1_a1", addr_q[base+1], 16'd10);
    check("t1_a2", addr_q[base+2], 16'd13);
    check("t1_a3", addr_q[base+3], 16'd14);
    @(negedge clk);

    // (4,4): both clamps active
    base = addr_q.size();
    req(16'd4, 16'd4, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    pix4("t2", 16'h010F, 16'h010F, 16'h010F, 16'h010F);
    check("t2_nreads", addr_q.size() - base, 4);
    for (int k = 0; k < 4; k++) check("t2_addr", addr_q[base+k], 16'd15);
    @(negedge clk);

    // Out-of-range requests
    base = addr_q.size();
    req(16'd0, 16'd2, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    check("t3_latency", lat, 0);
    check("t3_err", coord_err, 1'b1);
    pix4("t3", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    req(16'd5, 16'd1, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    check("t3b_err", coord_err, 1'b1);
    pix4("t3b", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check("t3_no_reads", addr_q.size() - base, 0);
    check("t3_err_clear", coord_err, 1'b0);

    // Back-pressure: 7 cycles stalled with req_valid pulses, accept on the 8th
    out_ready = 1'b0;
    req(16'd1, 16'd2, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    s0 = imgmn; s1 = imgm1n; s2 = imgmn1; s3 = imgm1n1;
    pix4("t4", 16'h0104, 16'h0105, 16'h0108, 16'h0109);
    for (int k = 1; k <= 7; k++) begin
      check("t4_hold_valid", out_valid, 1'b1);
      pix4("t4_hold", s0, s1, s2, s3);
      req_valid = k[0];
      src_x = 16'(k);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("t4_valid_8th", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_done_valid", out_valid, 1'b0);
    check("t4_done_ready", req_ready, 1'b1);

    // Reset while the fetch is in A2
    req(16'd1, 16'd2, acc);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_valid_low", out_valid, 1'b0);
      check("t5_addr_zero", mem_addr, 16'h0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("t5_rel_ready", req_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_output", out_valid, 1'b0);
    end
    req(16'd1, 16'd1, acc);
    req_valid = 1'b0;
    wait_valid(lat);
    pix4("t5", 16'h0100, 16'h0101, 16'h0104, 16'h0105);
    @(negedge clk);

    // Back-to-back scan of the whole 4x4 image
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      req(16'((i % 4) + 1), 16'((i / 4) + 1), acc);
      if (i > 0) check("t6_spacing", acc - prev_acc, 7);
      prev_acc = acc;
    end
    req_valid = 1'b0;
    wait_valid(lat);
    pix4("t6_last", 16'h010F, 16'h010F, 16'h010F, 16'h010F);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
